// File: rtl/blit_mem_write_pkg.sv
// Shared definitions for the blitter destination write-combining buffer.
// One line is 64 bytes, streamed to SDRAM as a 16-word masked burst.
package blit_mem_write_pkg;

   localparam int LINE_BYTES = 64;
   localparam int LINE_WORDS = 16;
   localparam int ADDR_W     = 26;
   localparam int LINE_AW    = ADDR_W - 6;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      REQ,
      DATA
   } blitw_state_t;

endpackage

// File: rtl/blit_mem_write_line_buf.sv
// One-line storage: 16x32 data written a byte at a time plus a per-byte dirty mask.
// Only the mask is reset; stale data bytes are harmless because their mask bits are clear.
module blit_line_buf
   import blit_mem_write_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [5:0]  wr_idx,
   input  logic [7:0]  wr_data,
   input  logic        clear_mask,
   input  logic [3:0]  rd_idx,
   output logic [31:0] rd_data,
   output logic [3:0]  rd_mask
);

   logic [3:0][7:0]       words_q [LINE_WORDS];
   logic [LINE_BYTES-1:0] mask_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         words_q[wr_idx[5:2]][wr_idx[1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
      end else if (clear_mask) begin
         mask_q <= '0;
      end else if (wr_en) begin
         mask_q[wr_idx] <= 1'b1;
      end
   end

   assign rd_data = words_q[rd_idx];
   assign rd_mask = mask_q[{rd_idx, 2'b00} +: 4];

endmodule

// File: rtl/blit_mem_write.sv
// Write-combining buffer between the p4 pixel stage and the SDRAM blitter-write port.
// Bytes merge into one open line; a miss or flush sends the whole line as a masked burst.
module blit_mem_write
   import blit_mem_write_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              p4_write,
   input  logic [ADDR_W-1:0] p4_dst_addr,
   input  logic [7:0]        p4_dst_data,
   input  logic              flush,
   output logic              stall,
   output logic              busy,
   output logic              blitw_sdram_req,
   output logic [ADDR_W-1:0] blitw_sdram_addr,
   input  logic              blitw_sdram_ack,
   input  logic              blitw_sdram_wrreq,
   output logic [31:0]       blitw_sdram_wdata,
   output logic [3:0]        blitw_sdram_wmask,
   input  logic              blitw_sdram_complete
);

   blitw_state_t       state;
   logic [LINE_AW-1:0] line_addr;
   logic [3:0]         rptr;
   logic               hit;
   logic               accept;
   logic               clear_mask;

   assign hit        = (p4_dst_addr[ADDR_W-1:6] == line_addr);
   assign accept     = p4_write && ((state == IDLE) || ((state == FILL) && hit));
   assign stall      = p4_write && ((state == REQ) || (state == DATA) ||
                                    ((state == FILL) && !hit));
   assign busy       = (state != IDLE);
   assign clear_mask = (state == DATA) && blitw_sdram_complete;

   blit_line_buf u_line_buf (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (accept),
      .wr_idx     (p4_dst_addr[5:0]),
      .wr_data    (p4_dst_data),
      .clear_mask (clear_mask),
      .rd_idx     (rptr),
      .rd_data    (blitw_sdram_wdata),
      .rd_mask    (blitw_sdram_wmask)
   );

   // A hit write and a flush in the same FILL cycle both take effect: the byte
   // merges through accept while the line moves on to REQ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         line_addr        <= '0;
         rptr             <= '0;
         blitw_sdram_req  <= 1'b0;
         blitw_sdram_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (p4_write) begin
                  line_addr <= p4_dst_addr[ADDR_W-1:6];
                  state     <= FILL;
               end
            end
            FILL: begin
               if ((p4_write && !hit) || flush) begin
                  blitw_sdram_req  <= 1'b1;
                  blitw_sdram_addr <= {line_addr, 6'b0};
                  state            <= REQ;
               end
            end
            REQ: begin
               if (blitw_sdram_ack) begin
                  blitw_sdram_req <= 1'b0;
                  rptr            <= '0;
                  state           <= DATA;
               end
            end
            DATA: begin
               if (blitw_sdram_wrreq) begin
                  rptr <= rptr + 4'd1;
               end
               if (blitw_sdram_complete) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blit_mem_write.sv
// Self-checking bench: a line-level model predicts stall/busy/req and every burst word.
// A simple SDRAM controller model answers requests with directed or random timing.
module tb_blit_mem_write;
   import blit_mem_write_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p4_write = 1'b0;
   logic [25:0] p4_dst_addr = '0;
   logic [7:0]  p4_dst_data = '0;
   logic        flush = 1'b0;
   logic        stall;
   logic        busy;
   logic        blitw_sdram_req;
   logic [25:0] blitw_sdram_addr;
   logic        blitw_sdram_ack = 1'b0;
   logic        blitw_sdram_wrreq = 1'b0;
   logic [31:0] blitw_sdram_wdata;
   logic [3:0]  blitw_sdram_wmask;
   logic        blitw_sdram_complete = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // controller model state
   bit rand_mode = 1'b0;
   int phase = 0;
   int cnt = 0;
   int left = 0;
   int bursts = 0;

   // line model: the open line, and the snapshot of the line being flushed
   logic [7:0]  m_bytes [64];
   bit   [63:0] m_mask = '0;
   logic [19:0] m_line = '0;
   bit          m_dirty = 1'b0;
   bit          m_flushing = 1'b0;
   bit          m_req_pending = 1'b0;
   int          m_widx = 0;
   logic [7:0]  x_bytes [64];
   bit   [63:0] x_mask = '0;
   logic [19:0] x_line = '0;

   logic [31:0] cap_data [16];
   logic [3:0]  cap_mask [16];
   int          cap_n = 0;
   logic [25:0] last_req_addr = '0;

   logic [3:0]  em;
   logic [31:0] ed;
   logic [31:0] lanes;
   bit          exp_stall;

   blit_mem_write dut (
      .clk                  (clk),
      .reset                (reset),
      .p4_write             (p4_write),
      .p4_dst_addr          (p4_dst_addr),
      .p4_dst_data          (p4_dst_data),
      .flush                (flush),
      .stall                (stall),
      .busy                 (busy),
      .blitw_sdram_req      (blitw_sdram_req),
      .blitw_sdram_addr     (blitw_sdram_addr),
      .blitw_sdram_ack      (blitw_sdram_ack),
      .blitw_sdram_wrreq    (blitw_sdram_wrreq),
      .blitw_sdram_wdata    (blitw_sdram_wdata),
      .blitw_sdram_wmask    (blitw_sdram_wmask),
      .blitw_sdram_complete (blitw_sdram_complete)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 7) + 3);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic write_byte(input logic [25:0] a, input logic [7:0] d, output int stalls);
      bit s;
      p4_write    = 1'b1;
      p4_dst_addr = a;
      p4_dst_data = d;
      stalls      = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         s = stall;
         step();
         if (!s) begin
            p4_write = 1'b0;
            return;
         end
         stalls++;
      end
      check_output("write_accept_timeout", 32'(stall), 32'd0);
      p4_write = 1'b0;
   endtask

   task automatic wait_idle();
      bit seen_c;
      seen_c = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (seen_c) begin
            check_output("busy_after_complete", 32'(busy), 32'd0);
            seen_c = 1'b0;
         end
         if (blitw_sdram_complete) begin
            check_output("busy_at_complete", 32'(busy), 32'd1);
            seen_c = 1'b1;
         end
         if (!busy && !blitw_sdram_complete && phase == 0) begin
            step();
            return;
         end
      end
      check_output("idle_timeout", 32'(busy), 32'd0);
      step();
   endtask

   task automatic wait_words(input int n);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cap_n >= n) return;
      end
      check_output("data_phase_timeout", 32'(cap_n), 32'(n));
   endtask

   task automatic apply_stimulus(inout bit hold);
      logic [19:0] rl;
      if (!hold) begin
         rl          = 20'($urandom_range(0, 3));
         p4_write    = ($urandom_range(0, 9) < 7);
         p4_dst_addr = {rl, 6'($urandom_range(0, 63))};
         p4_dst_data = 8'($urandom_range(0, 255));
      end
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      hold = p4_write && stall;
      step();
   endtask

   // SDRAM controller model
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset) continue;
         blitw_sdram_ack      = 1'b0;
         blitw_sdram_wrreq    = 1'b0;
         blitw_sdram_complete = 1'b0;
         if (phase == 0 && blitw_sdram_req) begin
            cnt   = rand_mode ? int'($urandom_range(0, 4)) : 3;
            phase = 1;
         end
         if (phase == 1) begin
            if (cnt == 0) begin
               blitw_sdram_ack = 1'b1;
               phase = 2;
               left  = 16;
            end else begin
               cnt--;
            end
         end else if (phase == 2) begin
            if (!rand_mode || $urandom_range(0, 3) != 0) begin
               blitw_sdram_wrreq = 1'b1;
               left--;
            end
            if (left == 0) begin
               phase = 3;
               cnt   = rand_mode ? int'($urandom_range(0, 3)) : 1;
            end
         end else if (phase == 3) begin
            if (cnt == 0) begin
               blitw_sdram_complete = 1'b1;
               phase = 0;
               bursts++;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial forever begin
      @(posedge reset);
      blitw_sdram_ack      = 1'b0;
      blitw_sdram_wrreq    = 1'b0;
      blitw_sdram_complete = 1'b0;
      phase = 0;
   end

   // line model: advances on the same edges the DUT samples its inputs
   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_dirty       = 1'b0;
         m_flushing    = 1'b0;
         m_req_pending = 1'b0;
         m_mask        = '0;
         m_widx        = 0;
      end else begin
         bit was_dirty, miss;
         was_dirty = m_dirty;
         miss = p4_write && was_dirty && (p4_dst_addr[25:6] != m_line);
         if (!m_flushing) begin
            if (p4_write && !miss) begin
               if (!was_dirty) m_line = p4_dst_addr[25:6];
               m_bytes[p4_dst_addr[5:0]] = p4_dst_data;
               m_mask[p4_dst_addr[5:0]]  = 1'b1;
               m_dirty = 1'b1;
            end
            if (was_dirty && (miss || flush)) begin
               x_bytes       = m_bytes;
               x_mask        = m_mask;
               x_line        = m_line;
               m_mask        = '0;
               m_dirty       = 1'b0;
               m_flushing    = 1'b1;
               m_req_pending = 1'b1;
            end
         end else if (m_req_pending) begin
            if (blitw_sdram_ack) begin
               m_req_pending = 1'b0;
               m_widx        = 0;
            end
         end else begin
            if (blitw_sdram_wrreq) m_widx = (m_widx + 1) % 16;
            if (blitw_sdram_complete) m_flushing = 1'b0;
         end
      end
   end

   // per-cycle compare against the model
   initial forever begin
      @(negedge clk);
      if (reset) continue;
      exp_stall = p4_write && (m_flushing || (m_dirty && (p4_dst_addr[25:6] != m_line)));
      check_output("stall", 32'(stall), 32'(exp_stall));
      check_output("busy", 32'(busy), 32'(m_dirty || m_flushing));
      check_output("req", 32'(blitw_sdram_req), 32'(m_req_pending));
      if (blitw_sdram_req) last_req_addr = blitw_sdram_addr;
      if (m_req_pending) begin
         check_output("req_addr", 32'(blitw_sdram_addr), 32'({x_line, 6'b0}));
      end
      if (blitw_sdram_wrreq) begin
         check_output("wrreq_outside_data", 32'(busy && !blitw_sdram_req), 32'd1);
         for (int b = 0; b < 4; b++) begin
            em[b]          = x_mask[m_widx * 4 + b];
            ed[b*8 +: 8]   = x_bytes[m_widx * 4 + b];
            lanes[b*8 +: 8] = {8{em[b]}};
         end
         check_output("wmask", 32'(blitw_sdram_wmask), 32'(em));
         check_output("wdata", blitw_sdram_wdata & lanes, ed & lanes);
         cap_data[m_widx] = blitw_sdram_wdata;
         cap_mask[m_widx] = blitw_sdram_wmask;
         cap_n++;
      end
   end

   initial begin
      int st, st2, total, nb;
      bit hold;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_req", 32'(blitw_sdram_req), 32'd0);
      check_output("reset_addr", 32'(blitw_sdram_addr), 32'd0);
      check_output("reset_stall", 32'(stall), 32'd0);
      reset = 1'b0;
      step();

      // three bytes into one line, explicit flush
      cap_n = 0;
      write_byte(26'h100, 8'hA1, st);
      write_byte(26'h101, 8'hB2, st);
      write_byte(26'h107, 8'hC3, st);
      pulse_flush();
      wait_idle();
      check_output("t1_addr", 32'(last_req_addr), 32'h100);
      check_output("t1_words", 32'(cap_n), 32'd16);
      check_output("t1_mask0", 32'(cap_mask[0]), 32'h3);
      check_output("t1_data0", cap_data[0] & 32'h0000FFFF, 32'h0000B2A1);
      check_output("t1_mask1", 32'(cap_mask[1]), 32'h8);
      check_output("t1_data1", cap_data[1] & 32'hFF000000, 32'hC3000000);
      nb = 0;
      for (int w = 2; w < 16; w++) nb += $countones(cap_mask[w]);
      check_output("t1_other_masks", 32'(nb), 32'd0);

      // line miss forces a flush; the missed byte opens the next line
      write_byte(26'h040, 8'h5A, st);
      write_byte(26'h080, 8'h6B, st2);
      check_output("t2_stall_cycles", 32'(st2), 32'd23);
      check_output("t2_addr", 32'(last_req_addr), 32'h040);
      cap_n = 0;
      pulse_flush();
      wait_idle();
      check_output("t2_new_line_addr", 32'(last_req_addr), 32'h080);
      check_output("t2_mask0", 32'(cap_mask[0]), 32'h1);
      check_output("t2_data0", cap_data[0] & 32'h000000FF, 32'h6B);

      // same byte written twice: last write wins
      cap_n = 0;
      write_byte(26'h045, 8'h11, st);
      write_byte(26'h045, 8'h22, st);
      pulse_flush();
      wait_idle();
      check_output("t3_mask1", 32'(cap_mask[1]), 32'h2);
      check_output("t3_data1", cap_data[1] & 32'h0000FF00, 32'h00002200);

      // flush while idle, and flush during the data phase
      st = bursts;
      pulse_flush();
      @(negedge clk);
      check_output("t4_idle_flush_busy", 32'(busy), 32'd0);
      check_output("t4_idle_flush_req", 32'(blitw_sdram_req), 32'd0);
      step();
      check_output("t4_idle_flush_bursts", 32'(bursts), 32'(st));
      cap_n = 0;
      write_byte(26'h1C0, 8'h3C, st);
      pulse_flush();
      st = bursts;
      wait_words(2);
      step();
      pulse_flush();
      wait_idle();
      repeat (5) step();
      check_output("t4_single_burst", 32'(bursts - st), 32'd1);
      check_output("t4_busy_after", 32'(busy), 32'd0);

      // reset in the middle of a burst
      cap_n = 0;
      write_byte(26'h240, 8'hAA, st);
      write_byte(26'h241, 8'hBB, st);
      pulse_flush();
      wait_words(5);
      @(posedge clk);
      #3;
      p4_write    = 1'b1;
      p4_dst_addr = 26'h203;
      p4_dst_data = 8'h77;
      reset       = 1'b1;
      #1;
      check_output("t5_req_in_reset", 32'(blitw_sdram_req), 32'd0);
      check_output("t5_busy_in_reset", 32'(busy), 32'd0);
      check_output("t5_stall_in_reset", 32'(stall), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      p4_write = 1'b0;
      cap_n = 0;
      pulse_flush();
      wait_idle();
      nb = 0;
      for (int w = 0; w < 16; w++) nb += $countones(cap_mask[w]);
      check_output("t5_fresh_mask_bits", 32'(nb), 32'd1);
      check_output("t5_mask0", 32'(cap_mask[0]), 32'h8);
      check_output("t5_data0", cap_data[0] & 32'hFF000000, 32'h77000000);

      // fill a complete line back to back
      total = 0;
      for (int i = 0; i < 64; i++) begin
         write_byte(26'h300 + 26'(i), pat(i), st);
         total += st;
      end
      check_output("t6_no_stalls", 32'(total), 32'd0);
      cap_n = 0;
      pulse_flush();
      wait_idle();
      for (int w = 0; w < 16; w++) begin
         check_output("t6_mask", 32'(cap_mask[w]), 32'hF);
         check_output("t6_data", cap_data[w],
                      {pat(4*w+3), pat(4*w+2), pat(4*w+1), pat(4*w)});
      end

      // randomized traffic over a few lines with random controller timing
      rand_mode = 1'b1;
      hold = 1'b0;
      for (int k = 0; k < 1500; k++) apply_stimulus(hold);
      p4_write = 1'b0;
      flush    = 1'b0;
      step();
      pulse_flush();
      wait_idle();
      check_output("final_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/blit_mem_write.md
Name: blit_mem_write

Overview:
- Write-combining buffer for the blitter pixel pipeline destination stream; opposite direction of the blitter source-read cache.
- Collects byte writes from pipeline stage p4 into one 64-byte line with per-byte enables.
- Flushes the line to the SDRAM controller as a 16-word masked burst on a line miss or on an explicit flush request.
- Sits between the p4 pixel stage and the SDRAM arbiter's blitter-write port.

Parameters:
- LINE_WORDS, 16, 32-bit words per line/burst (fixed; address split [25:6]/[5:2]/[1:0] follows from it)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p4_write  in  1  pixel write valid
- p4_dst_addr  in  26  byte address of pixel
- p4_dst_data  in  8  pixel byte
- flush  in  1  pulse: write out any pending line (end of blit)
- stall  out  1  pipeline must hold p4 inputs this cycle
- busy  out  1  buffer dirty or burst in progress
- blitw_sdram_req  out  1  burst request, held until ack
- blitw_sdram_addr  out  26  line address, 64-byte aligned
- blitw_sdram_ack  in  1  controller accepted request
- blitw_sdram_wrreq  in  1  controller consumes one data word this cycle
- blitw_sdram_wdata  out  32  word at current read pointer
- blitw_sdram_wmask  out  4  byte enables for that word
- blitw_sdram_complete  in  1  pulse: burst finished in SDRAM

Behaviour:
- Reset (async) values:
  - state=IDLE; all 64 mask bits 0; rptr=0
  - blitw_sdram_req=0, blitw_sdram_addr=0
  - stall=0, busy=0
  - Data RAM is not reset.
- States:
  - IDLE: buffer empty.
  - FILL: at least one byte dirty; line_addr valid.
  - REQ: req asserted.
  - DATA: streaming words.
- IDLE + p4_write: line_addr<=addr[25:6]; write byte at addr[5:0]; set its mask bit; go FILL. No stall.
- FILL + p4_write, hit (addr[25:6]==line_addr): merge byte and set its mask bit, one per cycle, no stall. Later writes to the same byte overwrite.
- FILL + p4_write, miss: stall=1 combinationally; the write is not accepted; go REQ.
- FILL + flush: go REQ. If flush and a hit write occur in the same cycle, the write merges first, then the line is flushed.
- IDLE + flush: no action.
- REQ:
  - On entry, blitw_sdram_req=1 and blitw_sdram_addr={line_addr,6'b0}.
  - Cycle with ack: req<=0; rptr<=0; go DATA.
- DATA:
  - blitw_sdram_wdata and blitw_sdram_wmask are driven combinationally from word[rptr] and mask[rptr].
  - Each wrreq cycle: rptr<=rptr+1, wrapping 15->0.
  - Words with wmask=0 are still sent; the controller suppresses them.
- DATA + complete: clear all mask bits; go IDLE.
  - A write stalled by a miss is accepted the following cycle via the IDLE path.
  - Latency: miss cycle to stall release = 1 (REQ) + ack wait + 16 wrreq + complete wait + 1.
- stall is asserted when p4_write and (state in {REQ, DATA} or FILL-miss). It is never asserted without p4_write.
- busy = state != IDLE. flush is ignored while in REQ or DATA; the requester polls busy.
- A wrreq outside DATA is a protocol error; the bench asserts it never occurs.
- Reset mid-burst: everything aborts immediately; pending data is lost (the controller is reset with it).

Decomposition:
- Shared blit package holds:
  - line constants LINE_BYTES=64, LINE_WORDS=16, ADDR_W=26
  - state enum blitw_state_t {IDLE, FILL, REQ, DATA}
- One sub-module, blit_line_buf: 16x32 data with byte write-enable and a 64-bit mask register.
  - Write port: byte index [5:0] plus data.
  - Combinational read port: word index.
  - Synchronous clear-mask input.
  - Async reset of the mask only.

Test Plan:
- Writes 0xA1/0xB2/0xC3 to 0x0000100, 0x0000101, 0x0000107, then flush; controller acks after 3 cycles -> one burst, addr 0x0000100:
  - word0 = 0x0000B2A1, wmask 4'b0011
  - word1 = 0xC3000000, wmask 4'b1000
  - other words wmask 0
  - busy drops 1 cycle after complete
- Write to 0x0000040 then to 0x0000080 -> stall high from the second write until 1 cycle after complete; burst addr 0x0000040; the second byte lands in the new line with line_addr=0x02.
- Two writes to 0x0000045 (0x11, then 0x22), then flush -> word1 = 0x00002200, wmask 4'b0010.
- flush in IDLE -> no req, busy stays 0; flush during DATA -> ignored, no second burst.
- Assert reset in DATA after 5 wrreq -> req=0, busy=0, stall=0 immediately; the next write starts a fresh line with only its own mask bit set.
- All 64 bytes written in 64 consecutive cycles, then flush -> no stalls; all 16 wmask = 4'hF; data matches byte-by-byte.
